// File: rtl/mux_4.sv
// Four-channel WIDTH-bit multiplexer with a combinational output plus registered
// copies of the selected data, the select value, and a select-change pulse.
module mux_4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q,
    output logic             sel_changed
);

    // Channel selection; an unknown select falls to default and yields all-X.
    always_comb begin
        out = {WIDTH{1'bx}};
        case (select)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            2'd3:    out = d;
            default: out = {WIDTH{1'bx}};
        endcase
    end

    // Registered copies of out and select, plus the one-cycle change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= {WIDTH{1'b0}};
            sel_q       <= 2'd0;
            sel_changed <= 1'b0;
        end else begin
            out_q       <= out;
            sel_q       <= select;
            sel_changed <= (select != sel_q);
        end
    end

endmodule

// File: tb/tb_mux_4.sv
// Self-checking bench for mux_4: directed steps followed by randomized traffic
// compared against a channel-array reference model.
module tb_mux_4;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a, b, c, d;
    logic [1:0]   select;
    logic [W-1:0] out, out_q;
    logic [1:0]   sel_q;
    logic         sel_changed;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_out_q;
    logic [1:0]   m_sel_q;
    logic         m_chg;

    mux_4 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d),
        .select(select),
        .out(out), .out_q(out_q), .sel_q(sel_q), .sel_changed(sel_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_out(input logic [W-1:0] ia, ib, ic, id,
                                             input logic [1:0] s);
        logic [W-1:0] ch [4];
        ch = '{ia, ib, ic, id};
        if ($isunknown(s)) return {W{1'bx}};
        return ch[s];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk(tag, {32'd0, out}, {32'd0, ref_out(a, b, c, d, select)});
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_out_q"}, {32'd0, out_q}, {32'd0, m_out_q});
        chk({tag, "_sel_q"}, {62'd0, sel_q}, {62'd0, m_sel_q});
        chk({tag, "_sel_changed"}, {63'd0, sel_changed}, {63'd0, m_chg});
    endtask

    // Advance one clock; the model captures what the registers should hold.
    task automatic tick(input string tag);
        logic [W-1:0] exp_out;
        logic [1:0]   s;
        exp_out = ref_out(a, b, c, d, select);
        s       = select;
        @(posedge clk);
        if (rst_n) begin
            m_chg   = (s != m_sel_q);
            m_out_q = exp_out;
            m_sel_q = s;
        end else begin
            m_chg   = 1'b0;
            m_out_q = '0;
            m_sel_q = 2'd0;
        end
        #1;
        chk_regs(tag);
    endtask

    initial begin
        m_out_q = '0; m_sel_q = 2'd0; m_chg = 1'b0;
        rst_n = 1'b0;
        a = 32'haaaaaaaa; b = 32'hbbbbbbbb; c = 32'hcccccccc; d = 32'hdddddddd;
        select = 2'd0;
        #2;
        chk_regs("reset");
        chk("basic_a", {32'd0, out}, {32'd0, 32'haaaaaaaa});
        @(negedge clk);
        rst_n = 1'b1;
        tick("first_edge");

        a = 32'habcdefff; #1;
        chk("a_update", {32'd0, out}, {32'd0, 32'habcdefff});
        b = 32'h11111111; c = 32'h22222222; d = 32'h33333333; #1;
        chk("nonsel_hold", {32'd0, out}, {32'd0, 32'habcdefff});
        b = 32'hbbbbbbbb; c = 32'hcccccccc; d = 32'hdddddddd;
        tick("hold0");

        select = 2'd1; #1;
        chk("sel1", {32'd0, out}, {32'd0, 32'hbbbbbbbb});
        tick("sel1");
        select = 2'd2; #1;
        chk("sel2", {32'd0, out}, {32'd0, 32'hcccccccc});
        tick("sel2");
        select = 2'd3; #1;
        chk("sel3", {32'd0, out}, {32'd0, 32'hdddddddd});
        tick("sel3");
        tick("sel3_settle");

        select = 2'd0; tick("to0");
        tick("to0_settle");
        select = 2'd2; tick("0to2_pulse");
        chk("pulse_high", {63'd0, sel_changed}, 64'd1);
        tick("0to2_after");
        chk("pulse_gone", {63'd0, sel_changed}, 64'd0);

        // Reset between edges clears registers without a clock.
        select = 2'd1; tick("pre_rst");
        #2;
        rst_n = 1'b0; #1;
        m_out_q = '0; m_sel_q = 2'd0; m_chg = 1'b0;
        chk_regs("async_rst");
        a = 32'h0badf00d; select = 2'd0; #1;
        chk_out("out_in_rst");
        tick("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        select = 2'd3;
        tick("release_cmp0");
        chk("release_pulse", {63'd0, sel_changed}, 64'd1);

        select = 2'bxx; #1;
        chk_out("sel_x");
        select = 2'd1; #1;

        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; c = $urandom; d = $urandom;
            select = 2'($urandom_range(0, 3));
            #1;
            chk_out("rand_out");
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_4.md
MUX_4 -- requirements
Module: mux_4

Interface
REQ-001 Parameter: WIDTH, default 32, data width of each input and output.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1: rising-edge clock for all registered outputs.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port a, input, WIDTH: channel 0 data.
REQ-006 Port b, input, WIDTH: channel 1 data.
REQ-007 Port c, input, WIDTH: channel 2 data.
REQ-008 Port d, input, WIDTH: channel 3 data.
REQ-009 Port select, input, 2: channel select, unsigned (0=a, 1=b, 2=c, 3=d).
REQ-010 Port out, output, WIDTH: combinational selected channel.
REQ-011 Port out_q, output, WIDTH: registered copy of out.
REQ-012 Port sel_q, output, 2: registered copy of select.
REQ-013 Port sel_changed, output, 1: single-cycle pulse, registered.

Function
REQ-014 out SHALL equal a/b/c/d for select 0/1/2/3 respectively, purely combinationally, with zero clock latency.
REQ-015 out SHALL respond to any change on the currently selected channel or on select within the same delta/time step; no clock or reset involvement.
REQ-016 Changes on non-selected channels SHALL NOT change out.
REQ-017 If select contains X/Z, out SHALL be all-X in simulation (no silent default to a).
REQ-018 out SHALL be valid regardless of rst_n state.
REQ-019 On each rising clk edge with rst_n high: out_q <= out, sel_q <= select.
REQ-020 out_q SHALL therefore lag out by exactly one clock cycle.
REQ-021 sel_changed SHALL be 1 for exactly the cycle following an edge at which select differed from sel_q, else 0.
REQ-022 No arithmetic; all data paths SHALL be bit-exact, WIDTH bits, no sign or zero extension.
REQ-023 WIDTH values 1 through 64 SHALL be supported.

Reset
REQ-024 rst_n low SHALL asynchronously force out_q = 0, sel_q = 0, sel_changed = 0, without waiting for clk.
REQ-025 While rst_n is low, the registered outputs SHALL hold 0.
REQ-026 Release of rst_n SHALL take effect at the next rising clk edge; the first edge after release compares select against sel_q = 0.
REQ-027 Reset asserted mid-operation SHALL clear the registered outputs immediately; out is unaffected.

Verification
REQ-028 a=aaaaaaaa, b=bbbbbbbb, c=cccccccc, d=dddddddd, select=0 -> out=aaaaaaaa.
REQ-029 Then a=abcdefff, select held at 0 -> out=abcdefff; changing b, c or d does not change out.
REQ-030 Select=1, 2, 3 in turn -> out=bbbbbbbb, cccccccc, dddddddd; each out_q matches one clk later.
REQ-031 Select 0->2 with rst_n high -> sel_changed=1 for exactly one cycle; sel_q=2.
REQ-032 Assert rst_n=0 between clk edges -> out_q, sel_q and sel_changed are 0 immediately; out still tracks the selected input.
REQ-033 Select=X -> out all-X; random a/b/c/d/select over 1000 cycles -> out and out_q match the reference model.
